fe25519_alu: RTL and testbench

Field-arithmetic responder for GF(p), p = 2^255-19. It executes one ADD/SUB/MUL/SQR/NEG/DBL command at a time, issued by the Ed25519 ladder sequencer's microcode dispatch. Execution is constant-time with respect to operand values: per-op latency is fixed and both arms of every conditional reduction are computed, then selected by mux. Results are always canonical (< p).

---
 rtl/fe25519_alu.sv | 175 +++++++++++++++++
 tb/tb_fe25519_alu.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fe25519_alu.sv
// fe25519_alu: constant-time field ALU for GF(p), p = 2^255-19.
// Executes one ADD/SUB/MUL/SQR/NEG/DBL command at a time; results are canonical.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_op                0 ADD, 1 SUB, 2 MUL, 3 SQR, 4 NEG, 5 DBL, 6-7 illegal
//   cmd_tag               opaque tag echoed on rsp_tag
//   cmd_a, cmd_b          256-bit operands (any value, reduced internally)
//   rsp_valid/rsp_ready   response handshake; response held until accepted
//   rsp_tag, rsp_data     echoed tag and canonical result
//   rsp_err               illegal opcode
//   busy                  command in flight or response pending
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// PREP  | reduce both operands to canonical form
// EXEC  | single-cycle ADD/SUB/NEG/DBL/illegal result
// ITER  | 255-step MSB-first double-and-add multiply (or uniform-time padding)
// RESP  | response presented until rsp_ready
module fe25519_alu #(
  parameter int TAG_W      = 5,
  parameter bit CT_UNIFORM = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [TAG_W-1:0] cmd_tag,
  input  logic [255:0]     cmd_a,
  input  logic [255:0]     cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [255:0]     rsp_data,
  output logic             rsp_err,
  output logic             busy
);

  localparam logic [255:0] P = {1'b0, {250{1'b1}}, 5'b01101};

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_SQR = 3'd3;
  localparam logic [2:0] OP_NEG = 3'd4;
  localparam logic [2:0] OP_DBL = 3'd5;

  typedef enum logic [2:0] {IDLE, PREP, EXEC, ITER, RESP} state_t;

  state_t             state, state_nx;
  logic [2:0]         op_q;
  logic [TAG_W-1:0]   tag_q;
  logic [255:0]       a_q, b_q, acc;
  logic [7:0]         cnt;

  // Conditional subtract of p for s < 2p. Bit 256 of the difference is the
  // borrow, so both arms exist and the select is a plain mux.
  function automatic logic [255:0] csub_p(input logic [256:0] s);
    logic [256:0] d;
    d = s - {1'b0, P};
    return d[256] ? s[255:0] : d[255:0];
  endfunction

  // Any 256-bit value folds below 2p because 2^255 = 19 (mod p).
  function automatic logic [255:0] reduce(input logic [255:0] x);
    return csub_p({2'b00, x[254:0]} + (x[255] ? 257'd19 : 257'd0));
  endfunction

  function automatic logic [255:0] add_mod(input logic [255:0] x, input logic [255:0] y);
    return csub_p({1'b0, x} + {1'b0, y});
  endfunction

  function automatic logic [255:0] sub_mod(input logic [255:0] x, input logic [255:0] y);
    logic [256:0] d;
    logic [255:0] w;
    d = {1'b0, x} - {1'b0, y};
    w = d[255:0] + P;
    return d[256] ? w : d[255:0];
  endfunction

  logic [255:0] short_res, acc_dbl, acc_add, acc_nx, final_data;
  logic         short_err, is_long, final_err;

  always_comb begin
    short_res = '0;
    short_err = 1'b0;
    case (op_q)
      OP_ADD:         short_res = add_mod(a_q, b_q);
      OP_SUB:         short_res = sub_mod(a_q, b_q);
      OP_NEG:         short_res = sub_mod('0, a_q);
      OP_DBL:         short_res = add_mod(a_q, a_q);
      OP_MUL, OP_SQR: short_res = '0;
      default:        short_err = 1'b1;
    endcase
  end

  // One ladder step; for padded short ops this runs as a dummy accumulator.
  always_comb begin
    acc_dbl = add_mod(acc, acc);
    acc_add = add_mod(acc_dbl, a_q);
    acc_nx  = b_q[cnt] ? acc_add : acc_dbl;
  end

  assign is_long    = (op_q == OP_MUL) || (op_q == OP_SQR);
  assign final_data = is_long ? acc_nx : short_res;
  assign final_err  = !is_long && short_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (cmd_valid) state_nx = PREP;
      PREP: state_nx = (is_long || CT_UNIFORM) ? ITER : EXEC;
      EXEC: state_nx = RESP;
      ITER: if (cnt == 8'd0) state_nx = RESP;
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      tag_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      cnt      <= '0;
      rsp_data <= '0;
      rsp_tag  <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          op_q  <= cmd_op;
          tag_q <= cmd_tag;
          a_q   <= cmd_a;
          b_q   <= cmd_b;
        end
        PREP: begin
          a_q <= reduce(a_q);
          b_q <= (op_q == OP_SQR) ? reduce(a_q) : reduce(b_q);
          acc <= '0;
          cnt <= 8'd254;
        end
        EXEC: begin
          rsp_data <= short_res;
          rsp_err  <= short_err;
          rsp_tag  <= tag_q;
        end
        ITER: begin
          acc <= acc_nx;
          cnt <= cnt - 8'd1;
          if (cnt == 8'd0) begin
            rsp_data <= final_data;
            rsp_err  <= final_err;
            rsp_tag  <= tag_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fe25519_alu.sv
// Testbench for fe25519_alu: two instances (CT_UNIFORM=0 and 1), directed
// vectors with hand-computed results, queue-based scoreboard with a separate
// monitor that checks data, tag, error flag and latency.
module tb_fe25519_alu;

  localparam logic [255:0] P   = {1'b0, {250{1'b1}}, 5'b01101};
  localparam logic [255:0] PM1 = P - 256'd1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid [2];
  logic         cmd_ready [2];
  logic [2:0]   cmd_op    [2];
  logic [4:0]   cmd_tag   [2];
  logic [255:0] cmd_a     [2];
  logic [255:0] cmd_b     [2];
  logic         rsp_valid [2];
  logic         rsp_ready [2];
  logic [4:0]   rsp_tag   [2];
  logic [255:0] rsp_data  [2];
  logic         rsp_err   [2];
  logic         busy      [2];

  always #5 clk = ~clk;

  fe25519_alu #(.TAG_W(5), .CT_UNIFORM(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]),
    .cmd_tag(cmd_tag[0]), .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_tag(rsp_tag[0]),
    .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]), .busy(busy[0]));

  fe25519_alu #(.TAG_W(5), .CT_UNIFORM(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]),
    .cmd_tag(cmd_tag[1]), .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_tag(rsp_tag[1]),
    .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]), .busy(busy[1]));

  typedef struct {
    int           k;
    logic [4:0]   tag;
    logic [255:0] data;
    logic         err;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   seen [2] = '{1'b0, 1'b0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: compares the presented response against the queue head every
  // cycle it is valid (so a stalled response must stay put) and pops on handshake.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rsp_valid[k]) begin
        if (sb.size() == 0 || sb[0].k != k) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rsp dut%0d: got tag %0d data %h, want no response", k, rsp_tag[k], rsp_data[k]);
        end else begin
          if (!seen[k]) begin
            seen[k] = 1'b1;
            chk($sformatf("latency dut%0d tag%0d", k, sb[0].tag), 256'(cyc - sb[0].acc), 256'(sb[0].lat));
          end
          chk($sformatf("rsp_data dut%0d tag%0d", k, sb[0].tag), rsp_data[k], sb[0].data);
          chk($sformatf("rsp_tag dut%0d", k), 256'(rsp_tag[k]), 256'(sb[0].tag));
          chk($sformatf("rsp_err dut%0d tag%0d", k, sb[0].tag), 256'(rsp_err[k]), 256'(sb[0].err));
          if (rsp_ready[k]) begin
            void'(sb.pop_front());
            seen[k] = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int k, input logic [2:0] op, input logic [4:0] tag,
                       input logic [255:0] a, input logic [255:0] b,
                       input logic [255:0] exp_data, input logic exp_err,
                       input int lat, input bit push);
    exp_t e;
    bit   done;
    done = 1'b0;
    cmd_valid[k] = 1'b1;
    cmd_op[k]    = op;
    cmd_tag[k]   = tag;
    cmd_a[k]     = a;
    cmd_b[k]     = b;
    for (int n = 0; n < 2000 && !done; n++) begin
      if (cmd_ready[k]) begin
        e.k = k; e.tag = tag; e.data = exp_data; e.err = exp_err;
        e.lat = lat; e.acc = cyc + 1;
        if (push) sb.push_back(e);
        done = 1'b1;
      end
      tick();
    end
    cmd_valid[k] = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout dut%0d tag%0d: got no cmd_ready, want accept", k, tag);
    end
  endtask

  task automatic wait_done();
    for (int n = 0; n < 600 && sb.size() != 0; n++) tick();
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rsp_timeout: got %0d pending responses, want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    logic [255:0] all1;
    bit           got;
    all1 = '1;
    for (int k = 0; k < 2; k++) begin
      cmd_valid[k] = 1'b0; cmd_op[k] = '0; cmd_tag[k] = '0;
      cmd_a[k] = '0; cmd_b[k] = '0; rsp_ready[k] = 1'b1;
    end

    #7;
    chk("reset cmd_ready", 256'(cmd_ready[0]), 256'd1);
    chk("reset rsp_valid", 256'(rsp_valid[0]), 256'd0);
    chk("reset rsp_data", rsp_data[0], 256'd0);
    chk("reset rsp_tag", 256'(rsp_tag[0]), 256'd0);
    chk("reset rsp_err", 256'(rsp_err[0]), 256'd0);
    chk("reset busy", 256'(busy[0]), 256'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Short ops, latency 2
    issue(0, 3'd0, 5'd7, PM1, 256'd1, 256'd0, 1'b0, 2, 1'b1);        wait_done();
    issue(0, 3'd1, 5'd1, 256'd0, 256'd1, PM1, 1'b0, 2, 1'b1);         wait_done();
    issue(0, 3'd4, 5'd2, 256'd0, 256'd9, 256'd0, 1'b0, 2, 1'b1);      wait_done();
    issue(0, 3'd4, 5'd3, 256'd1, 256'd0, PM1, 1'b0, 2, 1'b1);         wait_done();
    issue(0, 3'd0, 5'd4, 256'd5, 256'd7, 256'd12, 1'b0, 2, 1'b1);     wait_done();
    issue(0, 3'd6, 5'd5, 256'd5, 256'd7, 256'd0, 1'b1, 2, 1'b1);      wait_done();

    // MUL/SQR, latency 256
    issue(0, 3'd2, 5'd8, PM1, PM1, 256'd1, 1'b0, 256, 1'b1);          wait_done();
    issue(0, 3'd3, 5'd9, 256'd1 << 128, 256'd0, 256'd38, 1'b0, 256, 1'b1); wait_done();
    issue(0, 3'd2, 5'd10, all1, 256'd2, 256'd74, 1'b0, 256, 1'b1);    wait_done();

    // Back-pressure on DBL 2^254 -> 19
    rsp_ready[0] = 1'b0;
    issue(0, 3'd5, 5'd11, 256'd1 << 254, 256'd0, 256'd19, 1'b0, 2, 1'b1);
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      if (rsp_valid[0]) got = 1'b1;
      else tick();
    end
    chk("stall rsp_valid seen", 256'(got), 256'd1);
    for (int n = 0; n < 10; n++) begin
      cmd_valid[0] = 1'b1; cmd_op[0] = 3'd0; cmd_tag[0] = 5'd30;
      cmd_a[0] = 256'd1; cmd_b[0] = 256'd1;
      chk("stall cmd_ready", 256'(cmd_ready[0]), 256'd0);
      tick();
    end
    cmd_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    chk("pre-handshake cmd_ready", 256'(cmd_ready[0]), 256'd0);
    tick();
    chk("post-handshake cmd_ready", 256'(cmd_ready[0]), 256'd1);
    wait_done();
    tick(); tick();

    // Reset in the middle of a MUL: no response for it
    issue(0, 3'd2, 5'd12, PM1, PM1, 256'd1, 1'b0, 256, 1'b0);
    for (int n = 0; n < 99; n++) tick();
    rst_n = 1'b0;
    #1;
    chk("midreset rsp_valid", 256'(rsp_valid[0]), 256'd0);
    chk("midreset cmd_ready", 256'(cmd_ready[0]), 256'd1);
    tick();
    rst_n = 1'b1;
    tick();
    issue(0, 3'd0, 5'd13, 256'd1, 256'd1, 256'd2, 1'b0, 2, 1'b1);     wait_done();

    // Uniform-latency instance: every op takes 256 cycles
    issue(1, 3'd6, 5'd14, 256'd3, 256'd4, 256'd0, 1'b1, 256, 1'b1);   wait_done();
    issue(1, 3'd0, 5'd15, 256'd3, 256'd4, 256'd7, 1'b0, 256, 1'b1);   wait_done();
    issue(1, 3'd4, 5'd16, 256'd1, 256'd0, PM1, 1'b0, 256, 1'b1);      wait_done();
    issue(1, 3'd2, 5'd17, 256'd3, 256'd5, 256'd15, 1'b0, 256, 1'b1);  wait_done();

    for (int n = 0; n < 5; n++) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
